// File: rtl/kw_map_pkg.sv
// Shared types and constants for the kernel/weight map loader.
package kw_map_pkg;

  localparam int K_W = 3;

  localparam logic MODE_LOAD  = 1'b0;
  localparam logic MODE_SHIFT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/kw_map_row.sv
// One map row of MAX_K entries: clear, masked parallel load, or shift-left with insert at column K-1.
// Single-cycle update; no backpressure, the sequencer strobes at most one operation per cycle.
module kw_map_row
  import kw_map_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int MAX_K  = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr_i,
  input  logic                    load_i,
  input  logic                    shift_i,
  input  logic [K_W-1:0]          k_i,
  input  logic [MAX_K*DATA_W-1:0] lanes_i,
  input  logic [DATA_W-1:0]       ins_i,
  output logic [MAX_K*DATA_W-1:0] row_o
);

  logic [MAX_K*DATA_W-1:0] row_q, row_d;
  logic [MAX_K*DATA_W-1:0] row_shifted;

  assign row_shifted = row_q >> DATA_W;

  // Columns at or beyond K are never written with data, so they keep the zeros left by the clear.
  always_comb begin
    row_d = row_q;
    for (int c = 0; c < MAX_K; c++) begin
      if (clr_i) begin
        row_d[c*DATA_W +: DATA_W] = '0;
      end else if (load_i) begin
        row_d[c*DATA_W +: DATA_W] = (c < int'(k_i)) ? lanes_i[c*DATA_W +: DATA_W] : '0;
      end else if (shift_i) begin
        if (c < int'(k_i) - 1) begin
          row_d[c*DATA_W +: DATA_W] = row_shifted[c*DATA_W +: DATA_W];
        end else if (c == int'(k_i) - 1) begin
          row_d[c*DATA_W +: DATA_W] = ins_i;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= '0;
    end else begin
      row_q <= row_d;
    end
  end

  assign row_o = row_q;

endmodule

// File: rtl/kw_map_loader.sv
// K x K kernel/weight map with fill sequencer: full load reads K rows, column shift reads one row.
// done_o at t0+K+2 (load) or t0+3 (shift); start_i is ignored while busy, bad requests pulse err_o.
module kw_map_loader
  import kw_map_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int RD_PORTS = 8,
  parameter int MAX_K    = 5,
  parameter int ADDR_W   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_i,
  input  logic                          mode_i,
  input  logic [K_W-1:0]                k_size_i,
  input  logic [ADDR_W-1:0]             base_addr_i,
  output logic                          rd_en_o,
  output logic [ADDR_W-1:0]             rd_addr_o,
  input  logic [RD_PORTS*DATA_W-1:0]    rd_data_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  output logic                          map_valid_o,
  output logic [K_W-1:0]                k_size_o,
  output logic [MAX_K*MAX_K*DATA_W-1:0] kw_map_o
);

  state_e              state_q, state_d;
  logic [K_W-1:0]      row_q, row_d;
  logic [K_W-1:0]      k_q, k_d;
  logic                mode_q, mode_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                cap_vld_q, cap_vld_d;
  logic [K_W-1:0]      cap_row_q, cap_row_d;
  logic                clr_map;
  logic                req_bad;

  assign req_bad = (k_size_i == '0) || (k_size_i > K_W'(MAX_K)) ||
                   ((mode_i == MODE_SHIFT) && (!valid_q || (k_size_i != k_q)));

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    k_d       = k_q;
    mode_d    = mode_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    clr_map   = 1'b0;
    // Read data arrives one cycle after the strobe, so capture tracks the row issued last cycle.
    cap_vld_d = rd_en_q;
    cap_row_d = row_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else begin
            state_d   = ST_FETCH;
            mode_d    = mode_i;
            row_d     = '0;
            rd_en_d   = 1'b1;
            rd_addr_d = base_addr_i;
            if (mode_i == MODE_LOAD) begin
              k_d     = k_size_i;
              valid_d = 1'b0;
              clr_map = 1'b1;
            end
          end
        end
      end
      ST_FETCH: begin
        if ((mode_q == MODE_SHIFT) || (row_q == k_q - K_W'(1))) begin
          state_d = ST_DRAIN;
        end else begin
          row_d     = row_q + K_W'(1);
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          rd_en_d   = 1'b1;
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        valid_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      k_q       <= '0;
      mode_q    <= MODE_LOAD;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      cap_vld_q <= 1'b0;
      cap_row_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      k_q       <= k_d;
      mode_q    <= mode_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      cap_vld_q <= cap_vld_d;
      cap_row_q <= cap_row_d;
    end
  end

  for (genvar r = 0; r < MAX_K; r++) begin : g_row
    logic row_load;
    logic row_shift;

    assign row_load  = cap_vld_q && (mode_q == MODE_LOAD) && (cap_row_q == K_W'(r));
    assign row_shift = cap_vld_q && (mode_q == MODE_SHIFT) && (K_W'(r) < k_q);

    kw_map_row #(
      .DATA_W (DATA_W),
      .MAX_K  (MAX_K)
    ) u_row (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (clr_map),
      .load_i  (row_load),
      .shift_i (row_shift),
      .k_i     (k_q),
      .lanes_i (rd_data_i[MAX_K*DATA_W-1:0]),
      .ins_i   (rd_data_i[r*DATA_W +: DATA_W]),
      .row_o   (kw_map_o[r*MAX_K*DATA_W +: MAX_K*DATA_W])
    );
  end

  if (RD_PORTS > MAX_K) begin : g_spare_lanes
    logic unused_lanes;
    assign unused_lanes = ^rd_data_i[RD_PORTS*DATA_W-1:MAX_K*DATA_W];
  end

  assign rd_en_o     = rd_en_q;
  assign rd_addr_o   = rd_addr_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign map_valid_o = valid_q;
  assign k_size_o    = k_q;

endmodule

// File: tb/tb_kw_map_loader.sv
// Directed plus randomized bench for kw_map_loader against an array-level reference model.
module tb_kw_map_loader;

  localparam int DATA_W   = 16;
  localparam int RD_PORTS = 8;
  localparam int MAX_K    = 5;
  localparam int ADDR_W   = 8;
  localparam int MAPW     = MAX_K*MAX_K*DATA_W;

  logic                       clk;
  logic                       reset;
  logic                       start_i;
  logic                       mode_i;
  logic [2:0]                 k_size_i;
  logic [ADDR_W-1:0]          base_addr_i;
  logic                       rd_en_o;
  logic [ADDR_W-1:0]          rd_addr_o;
  logic [RD_PORTS*DATA_W-1:0] rd_data_i;
  logic                       busy_o;
  logic                       done_o;
  logic                       err_o;
  logic                       map_valid_o;
  logic [2:0]                 k_size_o;
  logic [MAPW-1:0]            kw_map_o;

  kw_map_loader #(
    .DATA_W   (DATA_W),
    .RD_PORTS (RD_PORTS),
    .MAX_K    (MAX_K),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .mode_i      (mode_i),
    .k_size_i    (k_size_i),
    .base_addr_i (base_addr_i),
    .rd_en_o     (rd_en_o),
    .rd_addr_o   (rd_addr_o),
    .rd_data_i   (rd_data_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .map_valid_o (map_valid_o),
    .k_size_o    (k_size_o),
    .kw_map_o    (kw_map_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Weight buffer contents and the reference model state.
  logic [DATA_W-1:0] mem [0:255][0:RD_PORTS-1];
  logic [DATA_W-1:0] m_map [0:MAX_K-1][0:MAX_K-1];
  int                m_k;
  bit                m_valid;
  logic [ADDR_W-1:0] rd_log [$];
  logic [RD_PORTS*DATA_W-1:0] rd_nxt;

  // Buffer answers one cycle after a strobe; otherwise drives junk that must be ignored.
  always @(posedge clk) begin
    for (int j = 0; j < RD_PORTS; j++) begin
      if (rd_en_o) rd_nxt[j*DATA_W +: DATA_W] = mem[rd_addr_o][j];
      else         rd_nxt[j*DATA_W +: DATA_W] = 16'($urandom);
    end
    rd_data_i <= rd_nxt;
  end

  always @(negedge clk) begin
    if (rd_en_o === 1'b1) rd_log.push_back(rd_addr_o);
  end

  task automatic chk(input string tag, input logic [MAPW-1:0] obs, input logic [MAPW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MAPW-1:0] flat_map();
    logic [MAPW-1:0] f;
    f = '0;
    for (int r = 0; r < MAX_K; r++)
      for (int c = 0; c < MAX_K; c++)
        f[(r*MAX_K+c)*DATA_W +: DATA_W] = m_map[r][c];
    return f;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < MAX_K; r++)
      for (int c = 0; c < MAX_K; c++)
        m_map[r][c] = '0;
    m_k = 0;
    m_valid = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_map"}, kw_map_o, flat_map());
    chk({tag, "_k"}, k_size_o, m_k);
    chk({tag, "_valid"}, map_valid_o, m_valid);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, rd_en_o, 0);
    chk({tag, "_rd_addr"}, rd_addr_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_err"}, err_o, 0);
    check_state(tag);
  endtask

  // One request from IDLE; optionally pokes start_i while busy and in the DONE cycle.
  task automatic req(input string tag, input logic mode, input int k, input int base, input bit inject);
    bit rej;
    bit seen_err;
    int n;
    int lat_exp;
    logic [ADDR_W-1:0] exp_rd [$];
    logic [DATA_W-1:0] old_map [0:MAX_K-1][0:MAX_K-1];

    rej = (k == 0) || (k > MAX_K) || (mode && (!m_valid || k != m_k));
    rd_log.delete();
    start_i     = 1'b1;
    mode_i      = mode;
    k_size_i    = k[2:0];
    base_addr_i = base[ADDR_W-1:0];
    @(negedge clk);
    start_i     = 1'b0;
    mode_i      = 1'($urandom);
    k_size_i    = 3'($urandom);
    base_addr_i = 8'($urandom);

    if (rej) begin
      chk({tag, "_err_pulse"}, err_o, 1);
      chk({tag, "_rej_busy"}, busy_o, 0);
      @(negedge clk);
      chk({tag, "_err_once"}, err_o, 0);
      chk({tag, "_rej_reads"}, rd_log.size(), 0);
      check_state(tag);
      return;
    end

    chk({tag, "_acc_busy"}, busy_o, 1);
    chk({tag, "_acc_valid"}, map_valid_o, mode);
    lat_exp  = mode ? 3 : k + 2;
    seen_err = 0;
    n = 1;
    while (done_o !== 1'b1 && n < 40) begin
      start_i = inject && (n == 2);
      @(negedge clk);
      n++;
      if (err_o === 1'b1) seen_err = 1;
    end
    chk({tag, "_done_lat"}, n, lat_exp);
    start_i = inject;
    @(negedge clk);
    start_i = 1'b0;
    chk({tag, "_done_once"}, done_o, 0);
    chk({tag, "_idle"}, busy_o, 0);
    chk({tag, "_no_err"}, seen_err | err_o, 0);

    if (mode == 1'b0) begin
      for (int r = 0; r < MAX_K; r++)
        for (int c = 0; c < MAX_K; c++)
          m_map[r][c] = (r < k && c < k) ? mem[(base + r) % 256][c] : '0;
      for (int r = 0; r < k; r++) exp_rd.push_back(8'((base + r) % 256));
      m_k = k;
    end else begin
      old_map = m_map;
      for (int r = 0; r < k; r++)
        for (int c = 0; c < k; c++)
          m_map[r][c] = (c < k - 1) ? old_map[r][c+1] : mem[base % 256][r];
      exp_rd.push_back(8'(base % 256));
    end
    m_valid = 1;

    chk({tag, "_nreads"}, rd_log.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
      chk({tag, "_rd_addr"}, rd_log[i], exp_rd[i]);
    check_state(tag);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int n = 0; n < 256; n++)
      for (int j = 0; j < RD_PORTS; j++)
        mem[n][j] = 16'(n*16 + j);
    for (int j = 0; j < RD_PORTS; j++) mem[8'h20][j] = 16'(16'hA0 + j);
    model_clear();

    reset = 1'b1; start_i = 1'b0; mode_i = 1'b0; k_size_i = '0; base_addr_i = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Full load, shift of that map, then rejected requests.
    req("t1_load3", 1'b0, 3, 8'h10, 0);
    chk("t1_e21", kw_map_o[(2*MAX_K+1)*DATA_W +: DATA_W], 16'h121);
    req("t3_shift3", 1'b1, 3, 8'h20, 0);
    chk("t3_e02", kw_map_o[(0*MAX_K+2)*DATA_W +: DATA_W], 16'hA0);
    req("t4_shift_k4", 1'b1, 4, 8'h30, 0);
    req("t4_k0", 1'b0, 0, 8'h30, 0);
    req("t4_k6", 1'b0, 6, 8'h30, 0);

    // Reload with a smaller K must clear the outer rows and columns.
    req("t2_load5", 1'b0, 5, 8'h40, 0);
    req("t2_load3", 1'b0, 3, 8'h50, 0);

    // Starts while busy and in DONE are ignored; the next idle start is taken.
    req("t5_inject", 1'b0, 3, 8'h60, 1);
    req("t5_inject_shift", 1'b1, 3, 8'h61, 1);
    req("t5_after", 1'b0, 2, 8'h70, 0);

    // Reset in the middle of a K=5 fetch.
    rd_log.delete();
    start_i = 1'b1; mode_i = 1'b0; k_size_i = 3'd5; base_addr_i = 8'h80;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    model_clear();
    check_reset_outputs("t6_reset");
    reset = 1'b0;
    req("t6_shift_invalid", 1'b1, 3, 8'h20, 0);
    req("t6_reload", 1'b0, 5, 8'h80, 0);

    req("wrap_load3", 1'b0, 3, 8'hFF, 0);

    for (int n = 0; n < 256; n++)
      for (int j = 0; j < RD_PORTS; j++)
        mem[n][j] = 16'($urandom);
    for (int i = 0; i < 14; i++) begin
      logic m;
      int k;
      m = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) k = $urandom_range(0, 7);
      else if (m)                    k = m_k;
      else                           k = $urandom_range(1, MAX_K);
      req("rand", m, k, $urandom_range(0, 255), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
